// File: rtl/tmul_seq_if.sv
// Bus bundle for the tile-multiply row sequencer: tile control, A-buffer
// read port, skewed row output and result/status signals.
//
// Handshake: start is sampled on every rising clk edge and accepted only while
// busy is low; there is no ready signal and nothing is queued.
// a_rd_en/a_rd_addr form a fire-and-forget read whose data must appear on
// a_rd_data exactly one cycle later. res_valid marks a result row for one cycle
// and cannot be stalled.
interface tmul_seq_if #(
  parameter int STAGES = 16,
  parameter int EW     = 16
);
  logic                   start;
  logic [4:0]             cfg_rows;
  logic                   abort;
  logic                   a_rd_en;
  logic [3:0]             a_rd_addr;
  logic [STAGES*EW-1:0]   a_rd_data;
  logic [STAGES*EW-1:0]   row_a_elem;
  logic [STAGES-1:0]      stage_valid;
  logic                   b_lock;
  logic                   res_valid;
  logic [3:0]             res_row;
  logic                   busy;
  logic                   done;
  logic                   err;
  logic [1:0]             dbg_state;

  modport master (
    output start, cfg_rows, abort, a_rd_data,
    input  a_rd_en, a_rd_addr, row_a_elem, stage_valid, b_lock,
    input  res_valid, res_row, busy, done, err, dbg_state
  );

  modport slave (
    input  start, cfg_rows, abort, a_rd_data,
    output a_rd_en, a_rd_addr, row_a_elem, stage_valid, b_lock,
    output res_valid, res_row, busy, done, err, dbg_state
  );
endinterface

// File: rtl/tmul_seq.sv
// Tile-multiply row sequencer: reads N rows of A, feeds them diagonally
// skewed into a chain of STAGES FMA rows, tracks live rows through the chain
// and reports result rows in order 0..N-1.
module tmul_seq #(
  parameter int STAGES = 16,
  parameter int EW     = 16
) (
  input  logic       clk,
  input  logic       rst,
  tmul_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [4:0]        n_q, n_d;
  logic              rd_en_q, rd_en_d;
  logic [3:0]        addr_q, addr_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic [STAGES-1:0] sv_q, sv_d;
  logic              clr;
  logic              res_valid;
  logic              cfg_legal;
  logic [STAGES*EW-1:0] row_elem;

  assign res_valid = sv_q[STAGES-1];
  assign cfg_legal = (int'(bus.cfg_rows) >= 1) && (int'(bus.cfg_rows) <= STAGES);

  // Tile control: accept/reject start, issue N reads, wait for the last result row.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    rd_en_d = rd_en_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    done_d  = 1'b0;
    clr     = 1'b0;
    if (res_valid) cnt_d = cnt_q + 4'd1;
    case (state_q)
      S_IDLE: begin
        // abort wins over a simultaneous start; on its own it does nothing here
        if (bus.start && !bus.abort) begin
          if (cfg_legal) begin
            state_d = S_ISSUE;
            n_d     = bus.cfg_rows;
            rd_en_d = 1'b1;
            addr_d  = 4'd0;
            cnt_d   = 4'd0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (bus.abort) begin
          clr = 1'b1;
        end else if ({1'b0, addr_q} == n_q - 5'd1) begin
          rd_en_d = 1'b0;
          addr_d  = 4'd0;
          state_d = S_DRAIN;
        end else begin
          addr_d = addr_q + 4'd1;
        end
      end
      S_DRAIN: begin
        if (bus.abort) begin
          clr = 1'b1;
        end else if (res_valid && ({1'b0, cnt_q} == n_q - 5'd1)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (clr) begin
      state_d = S_IDLE;
      n_d     = 5'd0;
      rd_en_d = 1'b0;
      addr_d  = 4'd0;
      cnt_d   = 4'd0;
    end
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      n_q     <= 5'd0;
      rd_en_q <= 1'b0;
      addr_q  <= 4'd0;
      cnt_q   <= 4'd0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      rd_en_q <= rd_en_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  // Live-row marker: set when read data returns, then walks one stage per cycle.
  always_comb begin
    sv_d = {sv_q[STAGES-2:0], rd_en_q};
    if (clr) sv_d = '0;
  end

  // Live-row shift register.
  always_ff @(posedge clk) begin
    if (rst) sv_q <= '0;
    else     sv_q <= sv_d;
  end

  // Element 0 enters stage 0 straight from the read data.
  assign row_elem[0 +: EW] = sv_q[0] ? bus.a_rd_data[0 +: EW] : '0;

  for (genvar k = 1; k < STAGES; k++) begin : g_skew
    logic [EW-1:0] sk_q [k];
    logic [EW-1:0] sk_d [k];

    // Element k is delayed k cycles so it meets its row in stage k.
    always_comb begin
      for (int j = 0; j < k; j++) sk_d[j] = '0;
      if (!clr) begin
        sk_d[0] = bus.a_rd_data[k*EW +: EW];
        for (int j = 1; j < k; j++) sk_d[j] = sk_q[j-1];
      end
    end

    // Skew delay line for element k.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int j = 0; j < k; j++) sk_q[j] <= '0;
      end else begin
        for (int j = 0; j < k; j++) sk_q[j] <= sk_d[j];
      end
    end

    assign row_elem[k*EW +: EW] = sv_q[k] ? sk_q[k-1] : '0;
  end

  assign bus.a_rd_en     = rd_en_q;
  assign bus.a_rd_addr   = addr_q;
  assign bus.row_a_elem  = row_elem;
  assign bus.stage_valid = sv_q;
  assign bus.res_valid   = res_valid;
  assign bus.res_row     = cnt_q;
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.b_lock      = (state_q != S_IDLE);
  assign bus.done        = done_q;
  assign bus.err         = err_q;
  assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_tmul_seq.sv
// Bench for tmul_seq: table of tiles plus abort, reset, ignored-start and
// abort-in-DONE sequences, checked cycle by cycle against expected timing.
module tb_tmul_seq;
  localparam int STAGES = 16;
  localparam int EW     = 16;
  localparam int W      = STAGES * EW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  tmul_seq_if #(.STAGES(STAGES), .EW(EW)) u_if ();

  tmul_seq #(.STAGES(STAGES), .EW(EW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  // A buffer: one-cycle read latency
  logic [W-1:0] mem [16];
  always @(posedge clk) if (u_if.a_rd_en) u_if.a_rd_data <= mem[u_if.a_rd_addr];

  // ---------------- scoreboard state ----------------
  logic [19:0] exp_q[$];   // {cycle[15:0], row[3:0]}
  int checks = 0;
  int errors = 0;
  int t_s = 0, t_n = 0, t_end = -1, t_done = -1, err_cyc = -1;
  int wait_until = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      int c;
      int r;
      bit exp_en;
      bit exp_busy;
      logic [STAGES-1:0] exp_sv;
      logic [W-1:0] exp_elem;
      logic [19:0] e;
      c = cyc;
      exp_en = (t_n > 0) && (c >= t_s + 1) && (c <= t_s + t_n) && (c <= t_end);
      chk("a_rd_en", W'(u_if.a_rd_en), W'(exp_en));
      if (exp_en) chk("a_rd_addr", W'(u_if.a_rd_addr), W'(c - t_s - 1));
      exp_sv = '0;
      exp_elem = '0;
      for (int k = 0; k < STAGES; k++) begin
        r = c - t_s - 2 - k;
        if ((t_n > 0) && (r >= 0) && (r < t_n) && (c <= t_end)) begin
          exp_sv[k] = 1'b1;
          exp_elem[k*EW +: EW] = mem[r][k*EW +: EW];
        end
      end
      chk("stage_valid", W'(u_if.stage_valid), W'(exp_sv));
      chk("row_a_elem", u_if.row_a_elem, exp_elem);
      // rows beyond an abort/reset will never appear
      while (exp_q.size() > 0 && int'(exp_q[0][19:4]) > t_end) void'(exp_q.pop_front());
      if (u_if.res_valid) begin
        if (exp_q.size() == 0) chk("res_valid_unexpected", W'(1), W'(0));
        else begin
          e = exp_q.pop_front();
          chk("res_cycle_row", W'({c[15:0], u_if.res_row}), W'(e));
        end
      end else if (exp_q.size() > 0 && int'(exp_q[0][19:4]) == c) begin
        chk("res_valid_missing", W'(0), W'(1));
        void'(exp_q.pop_front());
      end
      exp_busy = (t_n > 0) && (c >= t_s + 1) && (c <= t_end);
      chk("busy", W'(u_if.busy), W'(exp_busy));
      chk("b_lock", W'(u_if.b_lock), W'(exp_busy));
      chk("done", W'(u_if.done), W'(c == t_done));
      chk("err", W'(u_if.err), W'(c == err_cyc));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic fill_mem(input bit ones);
    for (int r = 0; r < 16; r++)
      for (int k = 0; k < STAGES; k++)
        mem[r][k*EW +: EW] = (ones && r == 0) ? 16'h3C00 : 16'($urandom_range(1, 65535));
  endtask

  task automatic start_tile(input logic [4:0] rows, input bit legal);
    int s;
    @(negedge clk);
    s = cyc;
    if (legal) begin
      t_s = s; t_n = int'(rows); t_end = s + 17 + int'(rows); t_done = t_end;
      err_cyc = -1;
      for (int i = 0; i < int'(rows); i++) exp_q.push_back({16'(s + 17 + i), 4'(i)});
      wait_until = s + 19 + int'(rows);
    end else begin
      t_n = 0; t_done = -1; err_cyc = s + 1;
      wait_until = s + 4;
    end
    u_if.start = 1'b1;
    u_if.cfg_rows = rows;
    @(negedge clk);
    u_if.start = 1'b0;
  endtask

  task automatic wait_idle();
    while (cyc < wait_until) @(negedge clk);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_ctrl"}, W'({u_if.a_rd_en, u_if.a_rd_addr, u_if.stage_valid, u_if.res_valid,
        u_if.res_row, u_if.busy, u_if.b_lock, u_if.done, u_if.err, u_if.dbg_state}), W'(0));
    chk({name, "_row_a_elem"}, u_if.row_a_elem, '0);
  endtask

  // ---------------- test ----------------
  typedef struct {
    logic [4:0] rows;
    bit         legal;
    bit         ones;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{5'd16, 1'b1, 1'b0};
    vecs[1] = '{5'd1,  1'b1, 1'b1};
    vecs[2] = '{5'd0,  1'b0, 1'b0};
    vecs[3] = '{5'd17, 1'b0, 1'b0};
    vecs[4] = '{5'd5,  1'b1, 1'b0};
    vecs[5] = '{5'd31, 1'b0, 1'b0};
    vecs[6] = '{5'd2,  1'b1, 1'b0};
    vecs[7] = '{5'd9,  1'b1, 1'b0};

    rst = 1'b1;
    u_if.start = 1'b0;
    u_if.cfg_rows = 5'd0;
    u_if.abort = 1'b0;
    u_if.a_rd_data = '0;
    fill_mem(1'b0);
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    mon_en = 1'b1;

    // table of tiles, legal and illegal sizes
    for (int i = 0; i < 8; i++) begin
      fill_mem(vecs[i].ones);
      start_tile(vecs[i].rows, vecs[i].legal);
      wait_idle();
    end

    // start while busy is ignored; the running tile finishes unchanged
    fill_mem(1'b0);
    start_tile(5'd8, 1'b1);
    repeat (4) @(negedge clk);
    u_if.start = 1'b1;
    u_if.cfg_rows = 5'd3;
    @(negedge clk);
    u_if.start = 1'b0;
    wait_idle();

    // abort at S+10 of a full tile
    fill_mem(1'b0);
    start_tile(5'd16, 1'b1);
    repeat (9) @(negedge clk);
    u_if.abort = 1'b1;
    t_end = cyc;
    t_done = -1;
    wait_until = cyc + 4;
    @(negedge clk);
    u_if.abort = 1'b0;
    chk("abort_res_row", W'(u_if.res_row), W'(0));
    wait_idle();

    // reset at S+20, then a fresh tile with normal timing
    fill_mem(1'b0);
    start_tile(5'd16, 1'b1);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    t_end = cyc;
    t_done = -1;
    @(negedge clk);
    rst = 1'b0;
    chk_all_zero("mid_reset");
    fill_mem(1'b0);
    start_tile(5'd4, 1'b1);
    wait_idle();

    // abort during DONE is ignored
    fill_mem(1'b0);
    start_tile(5'd2, 1'b1);
    while (cyc < t_done) @(negedge clk);
    u_if.abort = 1'b1;
    @(negedge clk);
    u_if.abort = 1'b0;
    wait_idle();

    repeat (3) @(negedge clk);
    mon_en = 1'b0;
    chk("scoreboard_empty", W'(exp_q.size()), W'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
